md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit.sv | 142 ++++++++++++++
 tb/tb_md_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Purpose  : Multi-cycle multiply/divide unit that owns the HI/LO registers.
//            Supports mult, multu, div, divu and madd, plus mthi/mtlo writes.
// Revision : 1.0 - initial release
// ============================================================================
module md_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        wr_hi,
    input  logic        wr_lo,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_RUN   = 1'b1;

    localparam logic [2:0] c_OP_MULT  = 3'b000;
    localparam logic [2:0] c_OP_MULTU = 3'b001;
    localparam logic [2:0] c_OP_DIV   = 3'b010;
    localparam logic [2:0] c_OP_DIVU  = 3'b011;
    localparam logic [2:0] c_OP_MADD  = 3'b100;

    localparam logic [3:0] c_CNT_MUL = 4'd5;
    localparam logic [3:0] c_CNT_DIV = 4'd10;

    logic [0:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_op;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_start_ok;
    logic        w_wr_ok;
    logic        w_commit;
    logic        w_is_div_op;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [63:0] w_result;
    logic        w_result_en;

    assign busy = (r_state == c_S_RUN);
    assign HI   = r_hi;
    assign LO   = r_lo;

    assign w_start_ok  = (r_state == c_S_IDLE) && start && (op <= c_OP_MADD);
    assign w_wr_ok     = (r_state == c_S_IDLE) && !start;
    assign w_commit    = (r_state == c_S_RUN) && (r_cnt == 4'd1);
    assign w_is_div_op = (op == c_OP_DIV) || (op == c_OP_DIVU);

    // Sign-extend to 64 bits so an unsigned multiply yields the signed product mod 2^64
    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Signed divide via magnitudes; 0x80000000 / -1 wraps naturally to 0x80000000
    assign w_a_neg  = (r_op == c_OP_DIV) && r_a[31];
    assign w_b_neg  = (r_op == c_OP_DIV) && r_b[31];
    assign w_a_mag  = w_a_neg ? (32'd0 - r_a) : r_a;
    assign w_b_mag  = w_b_neg ? (32'd0 - r_b) : r_b;
    assign w_b_safe = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag  = w_a_mag / w_b_safe;
    assign w_r_mag  = w_a_mag % w_b_safe;
    assign w_quot   = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem    = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        w_result    = {r_hi, r_lo};
        w_result_en = 1'b1;
        case (r_op)
            c_OP_MULT:  w_result = w_prod_s;
            c_OP_MULTU: w_result = w_prod_u;
            c_OP_MADD:  w_result = {r_hi, r_lo} + w_prod_s;
            c_OP_DIV,
            c_OP_DIVU: begin
                w_result    = {w_rem, w_quot};
                w_result_en = (r_b != 32'd0);
            end
            default:    w_result_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_cnt   <= 4'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= 3'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_start_ok) begin
                        r_state <= c_S_RUN;
                        r_a     <= A;
                        r_b     <= B;
                        r_op    <= op;
                        r_cnt   <= w_is_div_op ? c_CNT_DIV : c_CNT_MUL;
                    end
                end
                c_S_RUN: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= c_S_IDLE;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase

            if (w_commit) begin
                if (w_result_en) begin
                    r_hi <= w_result[63:32];
                    r_lo <= w_result[31:0];
                end
            end else if (w_wr_ok) begin
                if (wr_hi) r_hi <= A;
                if (wr_lo) r_lo <= A;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_unit
// Purpose  : Self-checking bench for md_unit with directed and random operations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        wr_hi;
    logic        wr_lo;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit u_dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    endtask

    // Architectural result computed with 64-bit integer arithmetic
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint sa, sb, ua, ub, q, r;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            3'd0: return 64'(sa * sb);
            3'd1: return 64'(ua * ub);
            3'd2: begin
                if (b == 32'd0) return {hi, lo};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 32'd0) return {hi, lo};
                q = ua / ub;
                r = ua % ub;
                return {r[31:0], q[31:0]};
            end
            3'd4: return {hi, lo} + 64'(sa * sb);
            default: return {hi, lo};
        endcase
    endfunction

    // Called at a negedge with the unit idle; returns at the negedge where results are visible.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit inject);
        int nbusy;
        logic [63:0] exp;
        nbusy = (o == 3'd2 || o == 3'd3) ? 10 : 5;
        exp   = model(o, a, b, m_hi, m_lo);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < nbusy; i++) begin
            check($sformatf("busy_op%0d_c%0d", o, i + 1), {63'd0, busy}, 64'd1);
            check($sformatf("hold_op%0d_c%0d", o, i + 1), {HI, LO}, {m_hi, m_lo});
            if (inject && i == 1) begin
                start = 1'b1; op = 3'd2; A = 32'h1234; B = 32'd3; wr_hi = 1'b1;
            end
            @(negedge clk);
            start = 1'b0; wr_hi = 1'b0;
        end
        check($sformatf("done_op%0d", o), {63'd0, busy}, 64'd0);
        check($sformatf("res_op%0d", o), {HI, LO}, exp);
        {m_hi, m_lo} = exp;
    endtask

    task automatic write_regs(input logic h, input logic l, input logic [31:0] d);
        wr_hi = h; wr_lo = l; A = d;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        if (h) m_hi = d;
        if (l) m_lo = d;
        check("write", {HI, LO}, {m_hi, m_lo});
    endtask

    initial begin
        logic [2:0]  r_o;
        logic [31:0] r_a;
        logic [31:0] r_b;

        reset = 1'b1; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
        wr_hi = 1'b0; wr_lo = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_hilo", {HI, LO}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(3'd0, 32'hFFFFFFFF, 32'd2, 1'b0);
        check("mult_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFE);
        run_op(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
        check("multu_const", {HI, LO}, 64'h00000001_FFFFFFFE);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        check("div_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(3'd3, 32'd7, 32'd2, 1'b0);
        check("divu_const", {HI, LO}, 64'h00000001_00000003);

        write_regs(1'b1, 1'b0, 32'd0);
        write_regs(1'b0, 1'b1, 32'd10);
        run_op(3'd4, 32'd3, 32'd4, 1'b0);
        check("madd1_const", {HI, LO}, 64'd22);
        run_op(3'd4, 32'hFFFFFFFF, 32'd1, 1'b0);
        check("madd2_const", {HI, LO}, 64'd21);

        run_op(3'd0, 32'd5, 32'd6, 1'b1);
        check("inject_const", {HI, LO}, 64'd30);

        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check("div_ovf_const", {HI, LO}, 64'h00000000_80000000);

        write_regs(1'b1, 1'b1, 32'h55);
        write_regs(1'b1, 1'b0, 32'hAA);
        write_regs(1'b0, 1'b1, 32'hBB);
        run_op(3'd2, 32'd100, 32'd0, 1'b0);
        check("div0_const", {HI, LO}, 64'h000000AA_000000BB);

        // Reserved op with a simultaneous write: both must be dropped
        start = 1'b1; op = 3'd5; A = 32'hDEAD; wr_lo = 1'b1;
        @(negedge clk);
        start = 1'b0; wr_lo = 1'b0;
        check("rsvd_busy", {63'd0, busy}, 64'd0);
        check("rsvd_hilo", {HI, LO}, {m_hi, m_lo});
        @(negedge clk);
        check("rsvd_busy2", {63'd0, busy}, 64'd0);

        // Start with a write in the same cycle: start wins
        start = 1'b1; op = 3'd1; A = 32'd9; B = 32'd9; wr_hi = 1'b1;
        @(negedge clk);
        start = 1'b0; wr_hi = 1'b0;
        check("prio_busy", {63'd0, busy}, 64'd1);
        check("prio_hold", {HI, LO}, {m_hi, m_lo});
        repeat (5) @(negedge clk);
        m_hi = 32'd0; m_lo = 32'd81;
        check("prio_res", {HI, LO}, {m_hi, m_lo});

        // Abort a mult with reset at RUN cycle 3
        start = 1'b1; op = 3'd0; A = 32'd7; B = 32'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy_pre", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {HI, LO}, 64'd0);
        run_op(3'd1, 32'd3, 32'd5, 1'b0);
        write_regs(1'b1, 1'b1, 32'd0);
        repeat (6) @(negedge clk);
        check("abort_nocommit", {HI, LO}, 64'd0);

        for (int k = 0; k < 40; k++) begin
            r_o = 3'($urandom_range(0, 4));
            r_a = $urandom;
            case ($urandom_range(0, 3))
                0:       r_b = 32'd0;
                1:       r_b = $urandom_range(1, 9);
                2:       r_b = 32'd0 - $urandom_range(1, 9);
                default: r_b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0)
                write_regs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            run_op(r_o, r_a, r_b, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
